lcd_bus_scheduler: RTL and testbench

//  Shares one HD44780-style LCD bus between two write requesters: req0 (init/config sequencer) and req1 (display refresh).

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_phase_timer.sv | 38 +++
 rtl/lcd_bus_scheduler.sv | 145 ++++++++++++++
 tb/tb_lcd_bus_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus scheduler: state encoding, HD44780
// command bytes and the long-wait command classifier.
package lcd_pkg;

  localparam int unsigned LCD_CNT_W = 24;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2    = 8'hC0;

  // Clear (0x01) and return-home (0x02/0x03) need the long post-write wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by every bus phase; loading N makes done
// rise on the Nth cycle after the load edge.
module lcd_phase_timer
  import lcd_pkg::*;
#(
  parameter int unsigned RST_COUNT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LCD_CNT_W-1:0] load_val,
  output logic                 done
);

  logic [LCD_CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val - LCD_CNT_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LCD_CNT_W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= LCD_CNT_W'(RST_COUNT - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Round-robin arbiter for two LCD write requesters, turning each grant into
// one timed HD44780 bus cycle (setup, enable pulse, hold, busy wait).
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP    = 750000,
  parameter int unsigned T_SETUP      = 4,
  parameter int unsigned T_EN_HIGH    = 25,
  parameter int unsigned T_HOLD       = 4,
  parameter int unsigned T_WAIT_SHORT = 2500,
  parameter int unsigned T_WAIT_LONG  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam logic [LCD_CNT_W-1:0] L_SETUP = LCD_CNT_W'(T_SETUP);
  localparam logic [LCD_CNT_W-1:0] L_EN    = LCD_CNT_W'(T_EN_HIGH);
  localparam logic [LCD_CNT_W-1:0] L_HOLD  = LCD_CNT_W'(T_HOLD);
  localparam logic [LCD_CNT_W-1:0] L_SHORT = LCD_CNT_W'(T_WAIT_SHORT);
  localparam logic [LCD_CNT_W-1:0] L_LONG  = LCD_CNT_W'(T_WAIT_LONG);

  lcd_state_e           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 lcd_rs_q, lcd_rs_d;
  logic [7:0]           lcd_data_q, lcd_data_d;
  logic                 lcd_en_q, lcd_en_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 busy_q, busy_d;
  logic                 grant1;
  logic                 tmr_load;
  logic [LCD_CNT_W-1:0] tmr_val;
  logic                 tmr_done;

  // Reset preloads the timer so power-up needs no explicit load.
  lcd_phase_timer #(.RST_COUNT(T_POWERUP)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_data_d   = lcd_data_q;
    lcd_en_d     = lcd_en_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = L_SETUP;
    // With both requesting, last_grant=1 hands the bus to requester 0.
    grant1       = req1 && (!req0 || !last_grant_q);

    unique case (state_q)
      ST_PWRUP: if (tmr_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (req0 || req1) begin
          last_grant_d = grant1;
          lcd_rs_d     = grant1 ? rs1 : rs0;
          lcd_data_d   = grant1 ? data1 : data0;
          ack0_d       = !grant1;
          ack1_d       = grant1;
          tmr_load     = 1'b1;
          tmr_val      = L_SETUP;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          lcd_en_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = L_EN;
          state_d  = ST_EN_HI;
        end
      end
      ST_EN_HI: begin
        if (tmr_done) begin
          lcd_en_d = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = L_HOLD;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(lcd_rs_q, lcd_data_q) ? L_LONG : L_SHORT;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: if (tmr_done) state_d = ST_IDLE;
      default: state_d = ST_PWRUP;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PWRUP;
      last_grant_q <= 1'b1;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      lcd_en_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_data_q   <= lcd_data_d;
      lcd_en_q     <= lcd_en_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_q;
  assign lcd_data = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler: a grant scoreboard checks every ack,
// plus enable-pulse shape, write spacing, arbitration and mid-write reset.
module tb_lcd_bus_scheduler;
  import lcd_pkg::*;

  localparam int S = 2, E = 3, H = 2;
  localparam int P_SHORT = 1 + S + E + H + 5;
  localparam int P_LONG  = 1 + S + E + H + 20;
  localparam int BUDGET  = 200;

  typedef struct {
    logic       id;
    logic       rs;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, rs0, req1, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic ack_seen;

  lcd_bus_scheduler #(
    .T_POWERUP(10), .T_SETUP(S), .T_EN_HIGH(E), .T_HOLD(H),
    .T_WAIT_SHORT(5), .T_WAIT_LONG(20)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; any ack is scored.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    ack_seen = ack0 | ack1;
    if (ack_seen) begin
      check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_ack observed=ack0:%0b/ack1:%0b expected=none", ack0, ack1);
      end else begin
        e = sb.pop_front();
        check("ack_id", {31'd0, ack1}, {31'd0, e.id});
        check("cap_rs", {31'd0, lcd_rs}, {31'd0, e.rs});
        check("cap_data", {24'd0, lcd_data}, {24'd0, e.data});
      end
    end
  endtask

  task automatic push(input logic id, input logic rs, input logic [7:0] data);
    exp_t e;
    e.id = id; e.rs = rs; e.data = data;
    sb.push_back(e);
  endtask

  // Wait for the next ack; lcd_rs/lcd_data must hold their old values meanwhile.
  task automatic wait_ack(input string tag, input logic rs_h, input logic [7:0] d_h, output int t);
    t = -1;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (ack_seen) begin
        t = cyc;
        break;
      end
      check({tag, "_hold_rs"}, {31'd0, lcd_rs}, {31'd0, rs_h});
      check({tag, "_hold_data"}, {24'd0, lcd_data}, {24'd0, d_h});
    end
    if (t < 0) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no ack expected=ack within %0d cycles", tag, BUDGET);
    end
  endtask

  // Starting in the ack cycle: S low, E high, H low cycles of lcd_en.
  task automatic check_profile(input string tag, input logic rs_e, input logic [7:0] d_e);
    for (int i = 0; i < S + E + H; i++) begin
      if (i > 0) tick();
      check({tag, "_en"}, {31'd0, lcd_en}, {31'd0, (i >= S && i < S + E)});
      check({tag, "_rs"}, {31'd0, lcd_rs}, {31'd0, rs_e});
      check({tag, "_data"}, {24'd0, lcd_data}, {24'd0, d_e});
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
  endtask

  initial begin
    int t, prev, rel;
    rst = 1'b1;
    req0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
    req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
    tick(); tick();

    // Reset state
    check("rst_en", {31'd0, lcd_en}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    check("rst_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    // 1. Power-up: request held from reset, grant only after 10 cycles
    req0 = 1'b1; rs0 = 1'b0; data0 = LCD_CMD_FUNC_SET;
    push(1'b0, 1'b0, LCD_CMD_FUNC_SET);
    rst = 1'b0;
    rel = cyc;
    check("pwrup_busy0", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("pwrup_noack", {30'd0, ack1, ack0}, 32'd0);
      check("pwrup_busy", {31'd0, busy}, {31'd0, (i < 10)});
    end
    wait_ack("pwrup", 1'b0, 8'h00, t);
    check("pwrup_latency", t - rel, 32'd11);
    prev = t;

    // 2. Timing of a normal write, then requester 1 data write
    req0 = 1'b0;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h41;
    push(1'b1, 1'b1, 8'h41);
    check_profile("w38", 1'b0, LCD_CMD_FUNC_SET);
    wait_ack("w41", 1'b0, LCD_CMD_FUNC_SET, t);
    check("space_38", t - prev, P_SHORT);
    prev = t;

    // 6. Requester changes its inputs right after ack; captured value stays
    req1 = 1'b0; rs1 = 1'b0; data1 = 8'hFF;
    check_profile("w41", 1'b1, 8'h41);
    req0 = 1'b1; rs0 = 1'b0; data0 = LCD_CMD_CLEAR;
    push(1'b0, 1'b0, LCD_CMD_CLEAR);
    wait_ack("w01", 1'b1, 8'h41, t);
    check("space_41", t - prev, P_SHORT);
    prev = t;

    // 3. Clear gets the long wait, display-on the short one
    data0 = LCD_CMD_DISP_ON;
    push(1'b0, 1'b0, LCD_CMD_DISP_ON);
    check_profile("w01", 1'b0, LCD_CMD_CLEAR);
    wait_ack("w0c", 1'b0, LCD_CMD_CLEAR, t);
    check("space_01_long", t - prev, P_LONG);
    prev = t;

    data0 = LCD_CMD_LINE1;
    push(1'b0, 1'b0, LCD_CMD_LINE1);
    check_profile("w0c", 1'b0, LCD_CMD_DISP_ON);
    wait_ack("w80", 1'b0, LCD_CMD_DISP_ON, t);
    check("space_0c", t - prev, P_SHORT);

    // 5. Reset while lcd_en is high
    req0 = 1'b0;
    tick(); tick();
    check("pre_rst_en", {31'd0, lcd_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_en", {31'd0, lcd_en}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    check("midrst_ack", {30'd0, ack1, ack0}, 32'd0);
    tick(); tick();
    check("midrst_data", {24'd0, lcd_data}, 32'd0);

    // 4. Both requesters held high: req0 wins first after reset, then alternate
    req0 = 1'b1; rs0 = 1'b0; data0 = LCD_CMD_LINE2;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h42;
    push(1'b0, 1'b0, LCD_CMD_LINE2);
    push(1'b1, 1'b1, 8'h42);
    rst = 1'b0;
    rel = cyc;
    wait_ack("rr0", 1'b0, 8'h00, t);
    check("rerun_pwrup_latency", t - rel, 32'd11);
    prev = t;
    data0 = LCD_CMD_ENTRY;
    push(1'b0, 1'b0, LCD_CMD_ENTRY);
    wait_ack("rr1", 1'b0, LCD_CMD_LINE2, t);
    check("space_rr1", t - prev, P_SHORT);
    prev = t;
    data1 = 8'h43;
    push(1'b1, 1'b1, 8'h43);
    wait_ack("rr2", 1'b1, 8'h42, t);
    check("space_rr2", t - prev, P_SHORT);
    prev = t;
    wait_ack("rr3", 1'b0, LCD_CMD_ENTRY, t);
    check("space_rr3", t - prev, P_SHORT);
    req0 = 1'b0; req1 = 1'b0;

    // Drain: no further grants
    for (int i = 0; i < 30; i++) tick();
    check("sb_empty", sb.size(), 32'd0);
    check("final_idle_busy", {31'd0, busy}, 32'd0);
    check("final_rw", {31'd0, lcd_rw}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
